// File: rtl/sm4_key_sched.sv
// Iterative SM4 key schedule: expands a 128-bit master key one round per clock
// into a 32-entry round-key file, exposed through a registered read port.
module sm4_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic         keys_valid,
    output logic         busy,
    input  logic [4:0]   rd_addr,
    input  logic         rd_dec,
    output logic [31:0]  rd_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [127:0] FK = {32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [0:31][31:0] CK = {
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // Byte-wise S-box substitution (tau).
    function automatic logic [31:0] tau(input logic [31:0] a);
        tau = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    // Key-schedule linear transform: B ^ (B<<<13) ^ (B<<<23).
    function automatic logic [31:0] l_prime(input logic [31:0] b);
        l_prime = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    state_t         r_state;
    state_t         w_next_state;
    logic [127:0]   r_k;
    logic [4:0]     r_rnd;
    logic           r_keys_valid;
    logic [31:0]    r_rd_data;
    logic [31:0]    r_rf [0:31];
    logic [31:0]    w_rk;
    logic           w_accept;
    logic [4:0]     w_rd_idx;

    assign key_ready  = (r_state != S_EXPAND);
    assign busy       = (r_state == S_EXPAND);
    assign keys_valid = r_keys_valid;
    assign rd_data    = r_rd_data;

    // Round-key datapath, handshake qualifier and read address mapping.
    always_comb begin
        w_rk     = r_k[127:96] ^ l_prime(tau(r_k[95:64] ^ r_k[63:32] ^ r_k[31:0] ^ CK[r_rnd]));
        w_accept = key_valid & (r_state != S_EXPAND);
        // 31 - addr in 5 bits is a plain bit inversion
        if (rd_dec) begin
            w_rd_idx = ~rd_addr;
        end else begin
            w_rd_idx = rd_addr;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (key_valid) begin
                    w_next_state = S_EXPAND;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXPAND: begin
                if (r_rnd == 5'd31) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_EXPAND;
                end
            end
            S_DONE: begin
                if (key_valid) begin
                    w_next_state = S_EXPAND;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, working key, round counter, valid flag and read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_k          <= 128'd0;
            r_rnd        <= 5'd0;
            r_keys_valid <= 1'b0;
            r_rd_data    <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_k          <= key ^ FK;
                r_rnd        <= 5'd0;
                r_keys_valid <= 1'b0;
            end else if (r_state == S_EXPAND) begin
                r_k   <= {r_k[95:0], w_rk};
                r_rnd <= r_rnd + 5'd1;
                if (r_rnd == 5'd31) begin
                    r_keys_valid <= 1'b1;
                end
            end
            // Gated on the pre-edge flag so a half-built schedule is never visible
            r_rd_data <= r_keys_valid ? r_rf[w_rd_idx] : 32'd0;
        end
    end

    // Round-key file; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == S_EXPAND)) begin
            r_rf[r_rnd] <= w_rk;
        end
    end

endmodule

// File: tb/tb_sm4_key_sched.sv
// Directed bench for sm4_key_sched: standard vector, decrypt order, lockout,
// mid-run reset, back-to-back rekey and reset priority.
module tb_sm4_key_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         keys_valid;
    logic         busy;
    logic [4:0]   rd_addr;
    logic         rd_dec;
    logic [31:0]  rd_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rk [0:31];

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

    localparam logic [0:255][7:0] TB_SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    sm4_key_sched dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .keys_valid (keys_valid),
        .busy       (busy),
        .rd_addr    (rd_addr),
        .rd_dec     (rd_dec),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference key expansion; CK bytes are derived as (4i+j)*7 mod 256.
    task automatic model(input logic [127:0] mk);
        logic [31:0] k [0:3];
        logic [31:0] t, ck, b;
        logic [7:0]  byt;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                byt = 8'((4 * i + j) * 7);
                ck[31 - 8*j -: 8] = byt;
            end
            t = k[1] ^ k[2] ^ k[3] ^ ck;
            for (int j = 0; j < 4; j++) begin
                b[8*j +: 8] = TB_SBOX[t[8*j +: 8]];
            end
            t = k[0] ^ b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
            model_rk[i] = t;
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = t;
        end
    endtask

    // Accept a key on the next edge and walk the 32 expansion cycles.
    task automatic expand(input logic [127:0] mk, input bit lock);
        key       = mk;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("kv_drop_on_accept", {31'd0, keys_valid}, 32'd0);
        for (int n = 1; n <= 32; n++) begin
            if (lock && (n == 5 || n == 20)) begin
                key       = ~mk;
                key_valid = 1'b1;
                chk("lockout_key_ready", {31'd0, key_ready}, 32'd0);
            end
            step();
            key_valid = 1'b0;
            key       = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
            chk("rd_zero_in_expand", rd_data, 32'd0);
            chk("keys_valid_timing", {31'd0, keys_valid}, {31'd0, n == 32});
            chk("busy_timing", {31'd0, busy}, {31'd0, n < 32});
        end
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic d, input logic [31:0] exp);
        rd_addr = a;
        rd_dec  = d;
        step();
        chk(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key = 128'd0; rd_addr = 5'd0; rd_dec = 1'b0;
        step();
        step();
        chk("rst_key_ready", {31'd0, key_ready}, 32'd1);
        chk("rst_keys_valid", {31'd0, keys_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);

        // Reset priority over a simultaneous key request
        key = STD_KEY; key_valid = 1'b1;
        step();
        rst = 1'b0; key_valid = 1'b0;
        chk("rstprio_busy_a", {31'd0, busy}, 32'd0);
        step();
        chk("rstprio_busy_b", {31'd0, busy}, 32'd0);
        chk("rstprio_ready", {31'd0, key_ready}, 32'd1);
        chk("rstprio_kv", {31'd0, keys_valid}, 32'd0);

        // Standard vector
        model(STD_KEY);
        expand(STD_KEY, 1'b0);
        rd("std_rk0", 5'd0, 1'b0, 32'hF12186F9);
        rd("std_rk1", 5'd1, 1'b0, 32'h41662B61);
        rd("std_rk31", 5'd31, 1'b0, 32'h9124A012);
        rd("model_rk0", 5'd0, 1'b0, model_rk[0]);

        // Decrypt order
        rd("dec_a0", 5'd0, 1'b1, 32'h9124A012);
        rd("dec_a31", 5'd31, 1'b1, 32'hF12186F9);
        for (int i = 0; i < 32; i++) begin
            rd("dec_sweep", 5'(i), 1'b1, model_rk[31 - i]);
        end

        // Busy lockout with a different key pulsed mid-expansion
        rd_addr = 5'd0; rd_dec = 1'b0;
        expand(STD_KEY, 1'b1);
        for (int i = 0; i < 32; i++) begin
            rd("lock_sweep", 5'(i), 1'b0, model_rk[i]);
        end

        // Reset at EXPAND cycle 17
        key = STD_KEY; key_valid = 1'b1;
        step();
        key_valid = 1'b0;
        repeat (16) step();
        chk("mid_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", {31'd0, key_ready}, 32'd1);
        chk("midrst_kv", {31'd0, keys_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rd", rd_data, 32'd0);
        expand(STD_KEY, 1'b0);
        rd("rerun_rk0", 5'd0, 1'b0, 32'hF12186F9);

        // Back-to-back rekey in the first DONE cycle
        rd_addr = 5'd0; rd_dec = 1'b0;
        expand(STD_KEY, 1'b0);
        expand(128'd0, 1'b0);
        model(128'd0);
        rd("zero_rk0", 5'd0, 1'b0, model_rk[0]);
        rd("zero_rk31", 5'd31, 1'b0, model_rk[31]);
        rd("zero_dec0", 5'd0, 1'b1, model_rk[31]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm4_key_sched.md
# sm4_key_sched

Iterative SM4 key-schedule unit that sits directly upstream of the SM4 round datapath. It accepts a 128-bit master key, performs the 32-round SM4 key expansion one round per clock through the existing combinational key-expansion round (`Key_Expand`), and stores all 32 round keys in an internal register file. The round engine reads the stored keys through a registered read port, in either encryption order or decryption (reversed) order.

## Interface

Parameters: none. The round count (32) and the FK/CK constants are fixed by the SM4 standard.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: master-key request.
- `key` in 128: master key MK0..MK3; MK0 is `key[127:96]`.
- `key_ready` out 1: the block can accept a key (states IDLE and DONE).
- `keys_valid` out 1: all 32 round keys for the last accepted key are stored.
- `busy` out 1: expansion is in progress (state EXPAND).
- `rd_addr` in 5: round index requested by the round engine.
- `rd_dec` in 1: 0 reads `rk[rd_addr]`; 1 reads `rk[31-rd_addr]`.
- `rd_data` out 32: registered round key.

## Operation

State machine: IDLE, EXPAND, DONE.

**Constants**
- FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
- CK(i) comes from the key-expansion round's constant table, indexed by `rnd`.

**Internal state**
- Working register K[127:0].
- Round counter `rnd[4:0]`.
- Register file `rf[0:31][31:0]`.

**Key handshake**
- A key is accepted when `key_valid & key_ready` is high at a clock edge.
- On acceptance: K <= key ^ {FK0,FK1,FK2,FK3}, `rnd` <= 0, `keys_valid` <= 0, state <= EXPAND.

**EXPAND, each cycle**
- rk = K0 ^ L'(τ(K1^K2^K3^CK(rnd))), where L'(B) = B ^ (B<<<13) ^ (B<<<23).
- rf[rnd] <= rk.
- K <= {K1, K2, K3, rk}.
- `rnd` <= rnd+1.
- When `rnd` == 31: state <= DONE and `keys_valid` <= 1 instead of continuing. `rnd` wraps to 0.

**DONE**
- Keys are held indefinitely.
- A new key handshake restarts expansion exactly as from IDLE. `keys_valid` drops on the accept edge.

**EXPAND is not interruptible**
- `key_ready` = 0, so `key_valid` is ignored.
- `key` may change freely during EXPAND; it is sampled only on the accept edge.

**Read port**
- `rd_data` <= `keys_valid` ? rf[`rd_dec` ? 31-`rd_addr` : `rd_addr`] : 0.
- This is evaluated every cycle.
- Reads during EXPAND return 0. Partially written keys are never exposed.

**Width rules**
- 31-`rd_addr` is computed in 5 bits, so address 0 maps to 31 and address 31 maps to 0.
- All XORs are 32-bit; there is no arithmetic carry anywhere.

## Timing

**Reset**
- Values: state = IDLE, `key_ready` = 1, `keys_valid` = 0, `busy` = 0, `rd_data` = 0, `rnd` = 0, K = 0.
- `rf` is not cleared. It is unobservable while `keys_valid` = 0.
- Reset mid-EXPAND aborts expansion; the next key starts from round 0.
- Reset has priority over a simultaneous `key_valid`.

**Expansion latency** (accept edge = edge 0)
- `rf[i]` is written at edge i+1.
- `keys_valid` and `key_ready` are high after edge 32.
- `busy` is high from after edge 0 through edge 32.
- The expansion therefore takes exactly 32 cycles in EXPAND.

**Read latency**
- 1 cycle: the address presented before edge n appears on `rd_data` after edge n.
- The first valid read returns real data after edge 33.

**Back-to-back keys**
- A key may be accepted in the first DONE cycle; in that case `keys_valid` is high for only that one cycle.

**Outputs**
- `key_ready` and `busy` are decoded from the state register, not from inputs.
- No combinational path from inputs to any output.

## Test plan

1. **Standard vector.** Key 0123456789ABCDEFFEDCBA9876543210.
   - `keys_valid` rises exactly 32 cycles after the accept edge.
   - Reading `rd_addr` 0, 1, 31 with `rd_dec`=0 returns F12186F9, 41662B61, 9124A012.
2. **Decrypt order.** Same key, `rd_dec`=1.
   - `rd_addr` 0 returns 9124A012; `rd_addr` 31 returns F12186F9.
   - Sweep all 32 addresses and compare against a software model in reverse order.
3. **Busy lockout.** Pulse `key_valid` with a different key at cycles 5 and 20 of EXPAND.
   - `key_ready` = 0 and the request is ignored.
   - Final keys match test 1; `rd_data` = 0 throughout EXPAND.
4. **Reset mid-operation.** Assert `rst` at EXPAND cycle 17, then re-issue the vector key.
   - All outputs return to reset values in the cycle after reset.
   - The re-run yields rk0 = F12186F9 after a full 32 cycles.
5. **Back-to-back rekey.** In the first DONE cycle, present key 0.
   - `keys_valid` is high for exactly 1 cycle, then low for 32 cycles.
   - The new rk0 matches the software model for an all-zero key.
   - `rd_data` never shows a mixture of the old and new key schedules.
6. **Reset priority.** Assert `rst` and `key_valid` together in IDLE.
   - No expansion starts; `busy` stays 0.
